// File: rtl/button_event_pkg.sv
// button_event_pkg: shared event/state encodings for the button event scheduler
package button_event_pkg;
    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_LONG    = 2'd1,
        EV_REPEAT  = 2'd2,
        EV_RELEASE = 2'd3
    } event_type_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LONG = 2'd1,
        ST_REPEAT    = 2'd2
    } btn_state_t;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(a > b ? a : b);
    endfunction
endpackage

// File: rtl/button_event_fsm.sv
// button_event_fsm: per-button press/long/repeat/release event generator
module button_event_fsm
    import button_event_pkg::*;
#(
    parameter int LONG_PRESS_COUNTS = 25_000_000,
    parameter int REPEAT_COUNTS     = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level,
    output logic       ev_fire,
    output logic [1:0] ev_type
);
    localparam int CW = cnt_width(LONG_PRESS_COUNTS, REPEAT_COUNTS);
    localparam logic [CW-1:0] LONG_TERM = CW'(LONG_PRESS_COUNTS - 1);
    localparam logic [CW-1:0] REP_TERM  = CW'(REPEAT_COUNTS - 1);

    logic          prev_q, prev_d;
    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    event_type_t   ev_kind;
    logic          rise, fall;

    assign rise    = level & ~prev_q;
    assign fall    = ~level & prev_q;
    assign ev_type = ev_kind;

    // a falling level wins over a coincident counter terminal value
    always_comb begin
        prev_d  = level;
        state_d = state_q;
        cnt_d   = cnt_q;
        ev_fire = 1'b0;
        ev_kind = EV_PRESS;
        if (state_q == ST_IDLE) begin
            if (rise) begin
                ev_fire = 1'b1;
                state_d = ST_WAIT_LONG;
                cnt_d   = '0;
            end
        end else if (fall) begin
            ev_fire = 1'b1;
            ev_kind = EV_RELEASE;
            state_d = ST_IDLE;
        end else if (state_q == ST_WAIT_LONG && cnt_q == LONG_TERM) begin
            ev_fire = 1'b1;
            ev_kind = EV_LONG;
            state_d = ST_REPEAT;
            cnt_d   = '0;
        end else if (state_q == ST_REPEAT && cnt_q == REP_TERM) begin
            ev_fire = 1'b1;
            ev_kind = EV_REPEAT;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/button_event_scheduler.sv
// button_event_scheduler: per-button event slots serialised by a round-robin arbiter
module button_event_scheduler
    import button_event_pkg::*;
#(
    parameter int NUM_BUTTONS       = 4,
    parameter int LONG_PRESS_COUNTS = 25_000_000,
    parameter int REPEAT_COUNTS     = 5_000_000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_BUTTONS-1:0]         btn_level,
    output logic                           event_valid,
    input  logic                           event_ready,
    output logic [$clog2(NUM_BUTTONS)-1:0] event_id,
    output logic [1:0]                     event_type,
    output logic                           overflow,
    input  logic                           clear_overflow
);
    localparam int IW = $clog2(NUM_BUTTONS);

    logic [NUM_BUTTONS-1:0] ev_fire;
    logic [1:0]             ev_type [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] pend_valid_q, pend_valid_d;
    event_type_t            pend_type_q [NUM_BUTTONS];
    event_type_t            pend_type_d [NUM_BUTTONS];
    logic                   out_valid_q, out_valid_d;
    logic [IW-1:0]          out_id_q, out_id_d;
    event_type_t            out_type_q, out_type_d;
    logic [IW-1:0]          last_grant_q, last_grant_d;
    logic                   overflow_q, overflow_d;
    logic                   load, found, ovf_set;
    logic [IW-1:0]          gnt;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_event_fsm #(
            .LONG_PRESS_COUNTS(LONG_PRESS_COUNTS),
            .REPEAT_COUNTS    (REPEAT_COUNTS)
        ) u_fsm (
            .clk    (clk),
            .rst_n  (rst_n),
            .level  (btn_level[i]),
            .ev_fire(ev_fire[i]),
            .ev_type(ev_type[i])
        );
    end

    assign load = !out_valid_q || event_ready;

    always_comb begin
        found = 1'b0;
        gnt   = last_grant_q;
        for (int k = 1; k <= NUM_BUTTONS; k++) begin
            if (!found && pend_valid_q[IW'((int'(last_grant_q) + k) % NUM_BUTTONS)]) begin
                found = 1'b1;
                gnt   = IW'((int'(last_grant_q) + k) % NUM_BUTTONS);
            end
        end
    end

    // grant clears the slot first, so a granted slot reads as free to a new event
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_type_d  = pend_type_q;
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_type_d   = out_type_q;
        last_grant_d = last_grant_q;
        ovf_set      = 1'b0;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                out_id_d          = gnt;
                out_type_d        = pend_type_q[gnt];
                last_grant_d      = gnt;
                pend_valid_d[gnt] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (ev_fire[i]) begin
                ovf_set = ovf_set | pend_valid_d[i];
                if (!pend_valid_d[i] || ev_type[i] == EV_RELEASE) begin
                    pend_valid_d[i] = 1'b1;
                    pend_type_d[i]  = event_type_t'(ev_type[i]);
                end
            end
        end
        overflow_d = ovf_set | (overflow_q & ~clear_overflow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= '0;
            pend_type_q  <= '{default: EV_PRESS};
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_type_q   <= EV_PRESS;
            last_grant_q <= IW'(NUM_BUTTONS - 1);
            overflow_q   <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_type_q   <= out_type_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    assign event_valid = out_valid_q;
    assign event_id    = out_id_q;
    assign event_type  = out_type_q;
    assign overflow    = overflow_q;
endmodule

// File: doc/button_event_scheduler.md
# button_event_scheduler

Converts the debounced button levels produced by the per-button `debounce` instances into discrete, typed events. The event types are press, long-press, auto-repeat and release. Each button runs its own event FSM, and one pending event is held per button. A round-robin arbiter serialises the pending events onto a single valid/ready event port. The block sits between the debounce bank and the application control FSM, which consumes one event at a time.

## Interface
Parameters:
- `NUM_BUTTONS`, 4: number of debounced button inputs, 2..8.
- `LONG_PRESS_COUNTS`, 25_000_000: cycles of continuous press before a LONG event (0.5 s at 50 MHz); must be ≥ 2.
- `REPEAT_COUNTS`, 5_000_000: cycles between REPEAT events once a LONG event has been issued (0.1 s at 50 MHz); must be ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `btn_level`  in  NUM_BUTTONS: debounced, already-synchronised levels, 1 = pressed.
- `event_valid`  out  1: event on the output port is valid.
- `event_ready`  in  1: consumer accepts the event.
- `event_id`  out  $clog2(NUM_BUTTONS): index of the source button.
- `event_type`  out  2: PRESS=0, LONG=1, REPEAT=2, RELEASE=3.
- `overflow`  out  1: sticky flag; an event was dropped or overwritten.
- `clear_overflow`  in  1: synchronous clear of `overflow`.

## Operation
- Per-button state register `prev_level` resets to 0. A button that is high at release of reset therefore yields a PRESS event.
- Per-button FSM, counter `cnt` of width $clog2(max(LONG_PRESS_COUNTS, REPEAT_COUNTS)):
  - IDLE: on a rising level, emit PRESS, set `cnt`=0, go to WAIT_LONG.
  - WAIT_LONG: `cnt` increments each cycle. When `cnt`==LONG_PRESS_COUNTS-1, emit LONG, set `cnt`=0, go to REPEAT.
  - REPEAT: `cnt` increments each cycle. When `cnt`==REPEAT_COUNTS-1, emit REPEAT and set `cnt`=0. This repeats indefinitely.
  - Any state except IDLE: a falling level emits RELEASE and returns to IDLE. The falling level takes priority over a coincident counter terminal value.
- Pending slot per button holds `pend_valid` and `pend_type`:
  - A new event is written if the slot is empty or is being granted this cycle.
  - If the slot is occupied and not granted, a new RELEASE overwrites the slot.
  - If the slot is occupied and not granted, any other new event is discarded.
  - Either case (overwrite or discard) sets `overflow`.
- Arbiter:
  - The output register loads when `event_valid`==0, or when `event_valid`&&`event_ready`.
  - The search starts at `last_grant`+1 modulo NUM_BUTTONS and takes the first slot with `pend_valid`.
  - The granted slot clears, and `last_grant` takes the granted index.
  - If no slot is pending, `event_valid` drops to 0. An accepted event is never re-presented.
- `overflow`:
  - Set has priority over `clear_overflow` in the same cycle.
  - `clear_overflow` otherwise clears it on the next edge.
- Reset mid-operation forces every FSM to IDLE, empties all slots and clears the output register. Any event in flight is lost without setting `overflow`.

## Timing
- Reset values: `event_valid`=0, `event_id`=0, `event_type`=0, `overflow`=0, `last_grant`=NUM_BUTTONS-1, so the first search starts at button 0.
- Latency when the output register is free:
  - Level change sampled at edge t is written to the slot at edge t.
  - `event_valid` is asserted after edge t+1.
- The LONG event is emitted LONG_PRESS_COUNTS cycles after the PRESS event.
- Each REPEAT event follows the previous LONG or REPEAT by REPEAT_COUNTS cycles.
- Throughput: one event per cycle while `event_ready` is held at 1.
- `event_id` and `event_type` are stable while `event_valid`=1 and `event_ready`=0.

## Structure
- Package `button_event_pkg` holds:
  - `event_type_t` enum (PRESS, LONG, REPEAT, RELEASE).
  - `btn_state_t` enum (IDLE, WAIT_LONG, REPEAT).
- Sub-module `button_event_fsm`, one instance per button. It contains `prev_level`, the state register and `cnt`. Outputs are `ev_fire` (1-cycle pulse) and `ev_type`.
- The top level contains the pending slots, the round-robin arbiter, the output register and `overflow`.

## Test plan
Bench uses LONG_PRESS_COUNTS=8 and REPEAT_COUNTS=4.
- Button 0 high for 3 cycles with `event_ready`=1 → PRESS(id 0) two cycles after the rise, then RELEASE(id 0). No LONG event and `overflow`=0.
- Button 1 held for 20 cycles → PRESS, LONG 8 cycles later, then REPEAT at +4 and +8 and so on, then RELEASE after the fall.
- Buttons 0–3 rise in the same cycle with `event_ready`=1 → PRESS events in id order 0,1,2,3 on consecutive cycles. A second simultaneous burst is served starting after the last grant.
- `event_ready`=0 while button 2 presses and releases → PRESS is held stable on the port. RELEASE overwrites nothing because the PRESS already occupies the output register. A third event for button 2 sets `overflow`. `clear_overflow` then clears it.
- Assert `rst_n` low while button 3 is in REPEAT with an event valid → all outputs are 0 immediately. With the level still high after reset, a fresh PRESS(id 3) is emitted.
